// File: rtl/aes_inv_sbox_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_inv_sbox_arb                                             |
// | Two-requester round-robin front end for a shared 32-bit inverse      |
// | S-box. A granted 128-bit block is substituted one word per cycle.    |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module aes_inv_sbox_arb (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [127:0] blk0,
   input  logic         req1,
   input  logic [127:0] blk1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic [127:0] result,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [127:0]   r_block;
   logic [127:0]   r_result;
   logic [1:0]     r_idx;
   logic           r_last;
   logic           r_gnt0;
   logic           r_gnt1;
   logic           r_done;
   logic           r_done_id;
   logic           w_grant;
   logic           w_grant_id;
   logic [31:0]    w_word;

   // Arbitration and next-state logic; a tie goes to whoever was not served last.
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_grant_id   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req0 && (!req1 || r_last)) begin
               w_grant    = 1'b1;
               w_grant_id = 1'b0;
            end else if (req1) begin
               w_grant    = 1'b1;
               w_grant_id = 1'b1;
            end
            if (w_grant) begin
               w_next_state = S_SUB;
            end
         end
         S_SUB: begin
            if (r_idx == 2'd3) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Select the captured word currently being substituted (word0 is the MSW).
   always_comb begin
      w_word = 32'd0;
      case (r_idx)
         2'd0: w_word = r_block[127:96];
         2'd1: w_word = r_block[95:64];
         2'd2: w_word = r_block[63:32];
         2'd3: w_word = r_block[31:0];
         default: w_word = 32'd0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: capture on grant, fill one result word per SUB cycle, pulse done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_block   <= 128'd0;
         r_result  <= 128'd0;
         r_idx     <= 2'd0;
         r_last    <= 1'b1;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_block   <= w_grant_id ? blk1 : blk0;
                  r_gnt0    <= ~w_grant_id;
                  r_gnt1    <= w_grant_id;
                  r_last    <= w_grant_id;
                  r_done_id <= w_grant_id;
                  r_idx     <= 2'd0;
               end
            end
            S_SUB: begin
               case (r_idx)
                  2'd0: r_result[127:96] <= new_sboxw;
                  2'd1: r_result[95:64]  <= new_sboxw;
                  2'd2: r_result[63:32]  <= new_sboxw;
                  2'd3: r_result[31:0]   <= new_sboxw;
                  default: ;
               endcase
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign done    = r_done;
   assign done_id = r_done_id;
   assign result  = r_result;
   assign busy    = (r_state != S_IDLE);
   assign sboxw   = (r_state == S_SUB) ? w_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_sbox_arb.sv
`default_nettype none
module tb_aes_inv_sbox_arb;

   localparam logic [0:255][7:0] INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   localparam logic [127:0] BLK_A = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] RES_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] BLK_B = 128'h00000000_00000000_00000000_63636363;
   localparam logic [127:0] RES_B = 128'h52525252_52525252_52525252_00000000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [127:0] blk0 = 128'd0;
   logic [127:0] blk1 = 128'd0;
   logic         gnt0, gnt1, busy, done, done_id;
   logic [127:0] result;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // External inverse S-box model.
   assign new_sboxw = {INV[sboxw[31:24]], INV[sboxw[23:16]], INV[sboxw[15:8]], INV[sboxw[7:0]]};

   aes_inv_sbox_arb dut (
      .clk(clk), .rst(rst),
      .req0(req0), .blk0(blk0), .req1(req1), .blk1(blk1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
      .result(result), .sboxw(sboxw), .new_sboxw(new_sboxw)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      int   gcount;
      int   gtime [4];
      logic gid [4];
      logic both_seen;
      logic early;
      logic saw_done;

      // Reset state
      #12;
      check("rst_busy",   {127'd0, busy}, 128'd0);
      check("rst_gnt",    {126'd0, gnt0, gnt1}, 128'd0);
      check("rst_done",   {126'd0, done, done_id}, 128'd0);
      check("rst_result", result, 128'd0);
      check("rst_sboxw",  {96'd0, sboxw}, 128'd0);
      rst = 1'b0;

      // Single requester 0
      @(negedge clk);
      blk0 = BLK_A;
      req0 = 1'b1;
      tick();
      check("t1_gnt0", {127'd0, gnt0}, 128'd1);
      check("t1_busy", {127'd0, busy}, 128'd1);
      check("t1_w0",   {96'd0, sboxw}, {96'd0, 32'h637c777b});
      req0 = 1'b0;
      tick();
      check("t1_gnt0_pulse", {127'd0, gnt0}, 128'd0);
      check("t1_w1", {96'd0, sboxw}, {96'd0, 32'hf26b6fc5});
      tick();
      check("t1_w2", {96'd0, sboxw}, {96'd0, 32'h3001672b});
      tick();
      check("t1_w3", {96'd0, sboxw}, {96'd0, 32'hfed7ab76});
      check("t1_nodone_early", {127'd0, done}, 128'd0);
      tick();
      check("t1_done",    {127'd0, done}, 128'd1);
      check("t1_done_id", {127'd0, done_id}, 128'd0);
      check("t1_result",  result, RES_A);
      check("t1_sboxw_done", {96'd0, sboxw}, 128'd0);
      tick();
      check("t1_done_pulse", {127'd0, done}, 128'd0);
      check("t1_idle", {127'd0, busy}, 128'd0);

      // Word order on requester 1
      blk1 = BLK_B;
      req1 = 1'b1;
      tick();
      check("t2_gnt1", {127'd0, gnt1}, 128'd1);
      req1 = 1'b0;
      check("t2_w0", {96'd0, sboxw}, 128'd0);
      tick();
      check("t2_w1", {96'd0, sboxw}, 128'd0);
      tick();
      check("t2_w2", {96'd0, sboxw}, 128'd0);
      tick();
      check("t2_w3", {96'd0, sboxw}, {96'd0, 32'h63636363});
      tick();
      check("t2_done",    {127'd0, done}, 128'd1);
      check("t2_done_id", {127'd0, done_id}, 128'd1);
      check("t2_result",  result, RES_B);
      tick();

      // Contention right after reset
      rst = 1'b1;
      #3;
      rst = 1'b0;
      blk0 = BLK_A;
      blk1 = BLK_B;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      check("t3_gnt0_first", {126'd0, gnt0, gnt1}, 128'd2);
      req0 = 1'b0;
      early = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k < 6 && gnt1) early = 1'b1;
         if (k == 4) begin
            check("t3_done0", {126'd0, done, done_id}, 128'd2);
            check("t3_res0", result, RES_A);
         end
         if (k == 6) begin
            check("t3_gnt1_at6", {126'd0, gnt0, gnt1}, 128'd1);
            req1 = 1'b0;
         end
         if (k == 10) begin
            check("t3_done1", {126'd0, done, done_id}, 128'd3);
            check("t3_res1", result, RES_B);
         end
      end
      check("t3_no_early_gnt1", {127'd0, early}, 128'd0);

      // Fairness with both requests held
      gcount = 0;
      both_seen = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int t = 1; t <= 22; t++) begin
         tick();
         if (gnt0 && gnt1) both_seen = 1'b1;
         if (gnt0 || gnt1) begin
            if (gcount < 4) begin
               gtime[gcount] = t;
               gid[gcount]   = gnt1;
            end
            gcount++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("t4_count", gcount, 4);
      check("t4_both", {127'd0, both_seen}, 128'd0);
      check("t4_order", {124'd0, gid[0], gid[1], gid[2], gid[3]}, {124'd0, 4'b0101});
      check("t4_spacing", {96'd0, 8'(gtime[1]-gtime[0]), 8'(gtime[2]-gtime[1]), 8'(gtime[3]-gtime[2]), 8'(gtime[0])},
            {96'd0, 8'd6, 8'd6, 8'd6, 8'd1});
      tick();
      tick();
      check("t4_idle", {127'd0, busy}, 128'd0);

      // Reset during the second SUB cycle
      blk1 = BLK_B;
      req1 = 1'b1;
      tick();
      check("t5_gnt1", {127'd0, gnt1}, 128'd1);
      req1 = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("t5_rst_ctl", {123'd0, busy, done, done_id, gnt0, gnt1}, 128'd0);
      check("t5_rst_result", result, 128'd0);
      check("t5_rst_sboxw", {96'd0, sboxw}, 128'd0);
      #1 rst = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      check("t5_no_done", {127'd0, saw_done}, 128'd0);
      blk1 = BLK_A;
      req1 = 1'b1;
      tick();
      check("t5_gnt1_again", {127'd0, gnt1}, 128'd1);
      req1 = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("t5_done", {126'd0, done, done_id}, 128'd3);
      check("t5_result", result, RES_A);
      tick();

      // Capture isolation
      blk0 = BLK_B;
      req0 = 1'b1;
      tick();
      check("t6_gnt0", {127'd0, gnt0}, 128'd1);
      req0 = 1'b0;
      blk0 = {128{1'b1}};
      for (int k = 0; k < 4; k++) tick();
      check("t6_done", {126'd0, done, done_id}, 128'd2);
      check("t6_result", result, RES_B);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
